tbus_arbiter: RTL
=================

// Module: tbus_arbiter
// PURPOSE
//  Upstream controller for a shared tristate data bus; decides which registered driver owns the bus.
//  Round-robin arbitrates N requesters and captures the winner's word into a register.
//  Drives that word onto the inout bus with a registered output enable.
//  Inserts idle (all-Z) turnaround cycles between tenures so two drivers never overlap.
//  Sits between the producer logic and the bus; downstream receivers sample BUS on BUS_STB.
// PARAMETERS
//  N_REQ       4   number of requesters (>=2)
//  WIDTH       8   bus data width
//  TURNAROUND  1   Z cycles between tenures (>=1)
//  MAX_HOLD    3   max words per tenure before forced release (>=1)
// PORTS
//  CLK      in     1              clock; all state updates on posedge
//  RST_N    in     1              synchronous reset, active low
//  REQ      in     N_REQ          per-requester valid; DATA held stable while REQ=1
//  DATA     in     N_REQ*WIDTH    requester i word in DATA[i*WIDTH +: WIDTH]
//  ACK      out    N_REQ          combinational ready; word i transferred on edge with REQ[i]&ACK[i]
//  BUS      inout  WIDTH          shared bus: BUS_OE ? save : {WIDTH{1'bz}}
//  BUS_OE   out    1              registered drive enable
//  BUS_STB  out    1              =BUS_OE; one bus word per cycle while high
//  OWNER    out    clog2(N_REQ)   index of current/last owner
//  ERR      out    1              sticky contention flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (RST_N=0 at edge): state=IDLE, BUS_OE=0, save=0, OWNER=0, rr_ptr=0, hold_cnt=0, turn_cnt=0, ERR=0.
//   ACK=0 while RST_N=0; BUS=Z from the first reset edge, including reset mid-DRIVE.
//  FSM IDLE -> DRIVE -> TURN -> IDLE.
//   IDLE: winner = first i with REQ[i]=1, searching rr_ptr, rr_ptr+1, ... mod N_REQ. ACK[winner]=1.
//    Edge with any REQ: save<=DATA[winner], OWNER<=winner, hold_cnt<=1, BUS_OE<=1, go DRIVE.
//   DRIVE: BUS=save, BUS_STB=1.
//    Continue if REQ[OWNER]=1 && hold_cnt<MAX_HOLD: ACK[OWNER]=1; at edge save<=DATA[OWNER],
//     hold_cnt++, stay DRIVE (back-to-back words, no gap).
//    Otherwise: ACK=0; at edge BUS_OE<=0, rr_ptr<=(OWNER+1) mod N_REQ, turn_cnt<=TURNAROUND, go TURN.
//   TURN: BUS_OE=0, ACK=0; turn_cnt decrements each edge; leave for IDLE on the edge where it reaches 1.
//  Latency: word accepted at edge k is on BUS during cycle k+1.
//   Tenure gap = TURNAROUND Z cycles + 1 IDLE cycle.
//  At most one ACK bit is high in any cycle. REQ of non-owners is ignored during DRIVE/TURN.
//  Simultaneous requests: round-robin order; lowest index wins at rr_ptr=0.
//  rr_ptr wraps N_REQ-1 -> 0. hold_cnt saturates at MAX_HOLD; never wraps.
// CONFIGURATION
//  TBUS_CONTENTION_CHK_EN defined:
//   - In each DRIVE cycle, read BUS back and compare it to save with case inequality (X/Z count as mismatch).
//   - A mismatch sets ERR<=1 at that edge; ERR stays set until reset.
//  Not defined: ERR tied 0 and no readback logic is present.
// STRUCTURE
//  Package tbus_pkg: state enum typedef (IDLE, DRIVE, TURN); function clog2; OWNER width constant.
//  Sub-module tbus_rr_pick: combinational round-robin first-set search (REQ, rr_ptr -> winner, any).
//  Top: FSM, save register, counters, tristate assign, optional checker.
// TESTING (N_REQ=4, WIDTH=8, TURNAROUND=1, MAX_HOLD=3)
//  1. Reset: RST_N=0 for 2 edges -> BUS=8'hzz, BUS_OE=0, BUS_STB=0, ACK=0, OWNER=0, ERR=0.
//  2. Single word: REQ=4'b0010, DATA[1]=8'hA5 in cycle 0, dropped after ACK[1]
//     -> ACK=4'b0010 in cycle 0; cycle 1 BUS=8'hA5, STB=1, OWNER=1; cycle 2 BUS=Z; cycle 3 IDLE.
//  3. Burst cap: REQ[0] held, DATA advancing 01,02,03,04 on each accepted edge
//     -> BUS=01,02,03 in consecutive cycles, then 1 Z cycle, 1 IDLE cycle, then 04.
//  4. Fairness: REQ=4'b1111 held -> tenures owned by 0,1,2,3,0, each 3 words, separated by Z+IDLE.
//  5. Reset mid-burst: RST_N=0 during the 2nd DRIVE word
//     -> BUS=Z, BUS_OE=0 after that edge; next grant on REQ=4'b1111 goes to 0.
//  6. With TBUS_CONTENTION_CHK_EN: external driver forces BUS=8'h00 while 8'h01 is driven
//     -> ERR=1, held through later clean words until reset. Without the macro: ERR stays 0.

Source files
------------

// File: rtl/tbus_pkg.sv
// Shared types and helpers for the tristate bus arbiter (tbus_arbiter, tbus_rr_pick).
package tbus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_e;

  // Bits needed to index n items; never less than 1 so vectors stay legal.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned OWNER_W   = clog2(N_REQ_DEF);

endpackage

// File: rtl/tbus_rr_pick.sv
// Round-robin first-set search: scans req_i starting at ptr_i, wrapping modulo N_REQ.
module tbus_rr_pick
  import tbus_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req_i,
  input  logic [clog2(N_REQ)-1:0] ptr_i,
  output logic [clog2(N_REQ)-1:0] winner_o,
  output logic                    any_o
);

  localparam int unsigned PW = clog2(N_REQ);

  logic [PW-1:0] idx;

  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = PW'((32'(ptr_i) + k) % N_REQ);
      if (!any_o && req_i[idx]) begin
        any_o    = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/tbus_arbiter.sv
// Round-robin owner of a shared tristate bus with registered drive enable and Z turnaround.
// Optional readback contention checker enabled by defining TBUS_CONTENTION_CHK_EN.
module tbus_arbiter
  import tbus_pkg::*;
#(
  parameter int unsigned N_REQ      = N_REQ_DEF,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned MAX_HOLD   = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*WIDTH-1:0]    data_i,
  output logic [N_REQ-1:0]          ack_o,
  inout  wire  [WIDTH-1:0]          bus_io,
  output logic                      bus_oe_o,
  output logic                      bus_stb_o,
  output logic [clog2(N_REQ)-1:0]   owner_o,
  output logic                      err_o
);

  localparam int unsigned OWN_W  = clog2(N_REQ);
  localparam int unsigned HOLD_W = clog2(MAX_HOLD + 1);
  localparam int unsigned TURN_W = clog2(TURNAROUND + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   save_q, save_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [OWN_W-1:0]   rr_q, rr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [TURN_W-1:0]  turn_q, turn_d;
  logic               oe_q, oe_d;

  logic [OWN_W-1:0]   pick_winner;
  logic               pick_any;
  logic               cont_c;
  logic [N_REQ-1:0]   ack_c;
  logic [WIDTH-1:0]   data_w [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_data
    assign data_w[g] = data_i[g*WIDTH +: WIDTH];
  end

  tbus_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i    (req_i),
    .ptr_i    (rr_q),
    .winner_o (pick_winner),
    .any_o    (pick_any)
  );

  // Owner keeps the bus while it still requests and has burst budget left.
  assign cont_c = (state_q == DRIVE) && req_i[owner_q] && (32'(hold_q) < MAX_HOLD);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = DRIVE;
      DRIVE:   if (!cont_c) state_d = TURN;
      TURN:    if (turn_q == TURN_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Combinational ready: at most one bit, and silent while reset is asserted.
  always_comb begin
    ack_c = '0;
    if (rst_ni) begin
      case (state_q)
        IDLE:    if (pick_any) ack_c[pick_winner] = 1'b1;
        DRIVE:   if (cont_c) ack_c[owner_q] = 1'b1;
        default: ack_c = '0;
      endcase
    end
  end

  always_comb begin
    save_d  = save_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    oe_d    = oe_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          save_d  = data_w[pick_winner];
          owner_d = pick_winner;
          hold_d  = HOLD_W'(1);
          oe_d    = 1'b1;
        end
      end
      DRIVE: begin
        if (cont_c) begin
          save_d = data_w[owner_q];
          hold_d = hold_q + HOLD_W'(1);
        end else begin
          oe_d   = 1'b0;
          rr_d   = (32'(owner_q) == N_REQ - 1) ? '0 : owner_q + OWN_W'(1);
          turn_d = TURN_W'(TURNAROUND);
        end
      end
      TURN: begin
        turn_d = turn_q - TURN_W'(1);
      end
      default: oe_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      save_q  <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
      oe_q    <= 1'b0;
    end else begin
      save_q  <= save_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      oe_q    <= oe_d;
    end
  end

  assign bus_io    = oe_q ? save_q : {WIDTH{1'bz}};
  assign ack_o     = ack_c;
  assign bus_oe_o  = oe_q;
  assign bus_stb_o = oe_q;
  assign owner_o   = owner_q;

`ifdef TBUS_CONTENTION_CHK_EN
  logic err_q, err_d;

  // Any foreign driver, X or Z on the line while we drive is flagged until reset.
  always_comb begin
    err_d = err_q | ((state_q == DRIVE) && (bus_io !== save_q));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
